hc_ccip_responder: RTL and testbench
====================================

// Module: hc_ccip_responder
// PURPOSE
//   Memory-side CCI-P responder: the far end of the requestor's c0/c1 request channels.
//   It accepts read (c0) and write (c1) requests and serves them from an internal line memory.
//   It returns read data on c0 and write acks on c1.
//   It drives c0TxAlmFull/c1TxAlmFull back-pressure.
//   It is the stand-in host memory for AFU-level benches and loopback/self-test builds.
// PARAMETERS
//   MEM_LINES   1024  depth of internal memory in 512-bit cache lines (power of 2)
//   REQ_DEPTH   64    depth of each request FIFO (rd, wr), power of 2
//   ALM_SLACK   8     almost-full asserted when FIFO count >= REQ_DEPTH-ALM_SLACK
//   RD_LATENCY  4     cycles from read-FIFO pop to c0 rspValid (>=1)
// PORTS
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-low reset
//   ccip_c0_tx   in   t_if_ccip_c0_Tx  read requests (valid, hdr.address, hdr.mdata)
//   ccip_c1_tx   in   t_if_ccip_c1_Tx  write requests (valid, hdr.address, hdr.mdata, data)
//   rsp_stall    in   1      bench throttle; 1 = pop nothing from either FIFO this cycle
//   ccip_rx      out  t_if_ccip_Rx     c0/c1 responses + c0TxAlmFull/c1TxAlmFull
//   overflow     out  1      sticky: a request arrived while its FIFO was full
// BEHAVIOUR
//   Reset (reset==0, async):
//     - all ccip_rx valid bits, both AlmFull flags, overflow and FIFO counts -> 0
//     - read pipeline flushed; memory contents undefined; in-flight requests discarded
//   Address mapping: line index = hdr.address[$clog2(MEM_LINES)-1:0]; upper bits ignored (wrap).
//   Enqueue:
//     - c0 valid pushes {address, mdata} into RD FIFO; c1 valid pushes {address, mdata, data} into WR FIFO
//     - push while FIFO full: request dropped, overflow <= 1 until reset
//   Dequeue: each FIFO pops at most one entry per cycle when non-empty and rsp_stall==0.
//     Push and pop in the same cycle are allowed; count is unchanged.
//   Write path:
//     - WR pop writes data to memory at that clk edge
//     - next cycle: c1.rspValid=1, c1.hdr.resp_type=eRSP_WRLINE, mdata echoed
//   Read path:
//     - RD pop reads memory; shift pipeline of RD_LATENCY stages carries {valid, mdata, data}
//     - c0.rspValid=1, resp_type=eRSP_RDLINE, mdata echoed, c0.data valid same cycle only
//     - one response max per cycle; responses return in request order
//   Ordering/hazard: RD and WR pop same cycle, same line -> read returns NEW data (write-first).
//     Responses never reorder within a channel; no ordering between c0 and c1.
//   AlmFull: registered, c0TxAlmFull = (rd_count >= REQ_DEPTH-ALM_SLACK), c1 likewise for WR.
//     Requestors honour it; ALM_SLACK absorbs their pipeline.
//   Unused rx fields (c0 non-data hdr bits, c2 etc.) driven 0.
// TESTING
//   - Write line 5 data=0xA5.., mdata=0x11; 2 idle cycles; read line 5 mdata=0x22
//     -> c1 ack mdata 0x11 one cycle after pop; c0 rsp data 0xA5.. mdata 0x22 exactly RD_LATENCY after pop.
//   - rsp_stall=1, push 56 reads -> c0TxAlmFull=1 on cycle after 56th push; push 8 more -> full, overflow stays 0.
//     65th push -> overflow=1 sticky.
//   - Same-cycle RD/WR pop on line 9 (old 0x0, new 0x7) -> read returns 0x7.
//   - Address 0x400+3 with MEM_LINES=1024 -> aliases line 3; write via 3, read via 0x403 returns same data.
//   - Burst 32 reads, stall toggling every 3 cycles -> 32 responses in order, mdata 0..31, no gaps reordered.
//   - Assert reset mid-burst (10 reads in flight) -> rspValid 0 immediately, counts 0, AlmFull 0.
//     Post-reset read after a write works.

Source files
------------

// File: rtl/hc_ccip_responder.sv
// CCI-P host-memory stand-in: request FIFOs, a line memory, and read/write response paths.
// Read data returns RD_LATENCY cycles after pop, write ack one cycle after pop; rsp_stall freezes both pops.
package hc_ccip_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_WRLINE = 4'h1
  } t_ccip_rsp_type;

  typedef struct packed {
    logic [3:0]   req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [3:0]   req_type;
    logic         sop;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [1:0]     vc_used;
    logic           hit_miss;
    logic [1:0]     cl_num;
    t_ccip_rsp_type resp_type;
    t_ccip_mdata    mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]     vc_used;
    logic           hit_miss;
    logic           format;
    logic [1:0]     cl_num;
    t_ccip_rsp_type resp_type;
    t_ccip_mdata    mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

// Show-ahead circular FIFO; dout_o is the head entry whenever empty_o is low.
// Push while full is ignored; cnt_nxt_o is the count after this clock edge.
// Zero-latency pop; caller owns the backpressure policy.
module hc_ccip_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_nxt_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;
  assign cnt_d     = cnt_q + CW'(push_ok) - CW'(pop_ok);
  assign cnt_nxt_o = cnt_d;
  assign dout_o    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// Memory-side CCI-P responder serving c0 reads and c1 writes from an internal line memory.
// Latency: read RD_LATENCY cycles after pop, write ack 1 cycle after pop.
// Backpressure: registered AlmFull per channel; requests arriving at a full FIFO are dropped and flag overflow.
module hc_ccip_responder
  import hc_ccip_pkg::*;
#(
  parameter int unsigned MEM_LINES  = 1024,
  parameter int unsigned REQ_DEPTH  = 64,
  parameter int unsigned ALM_SLACK  = 8,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  t_if_ccip_c0_Tx ccip_c0_tx,
  input  t_if_ccip_c1_Tx ccip_c1_tx,
  input  logic           rsp_stall,
  output t_if_ccip_Rx    ccip_rx,
  output logic           overflow
);
  localparam int unsigned LW     = $clog2(MEM_LINES);
  localparam int unsigned CW     = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned ALM_TH = REQ_DEPTH - ALM_SLACK;

  typedef struct packed {
    logic [LW-1:0] line;
    t_ccip_mdata   mdata;
  } rd_ent_t;

  typedef struct packed {
    logic [LW-1:0] line;
    t_ccip_mdata   mdata;
    t_ccip_clData  data;
  } wr_ent_t;

  rd_ent_t       rd_in, rd_out;
  wr_ent_t       wr_in, wr_out;
  logic          rd_full, rd_empty, rd_pop;
  logic          wr_full, wr_empty, wr_pop;
  logic [CW-1:0] rd_cnt_nxt, wr_cnt_nxt;
  t_ccip_clData  rd_data_d;
  logic          unused_bits;

  t_ccip_clData        mem_q [MEM_LINES];
  logic [RD_LATENCY-1:0] rd_vld_q;
  t_ccip_mdata         rd_mdata_q [RD_LATENCY];
  t_ccip_clData        rd_data_q  [RD_LATENCY];
  logic                wr_rsp_vld_q;
  t_ccip_mdata         wr_rsp_mdata_q;
  logic                rd_alm_q, wr_alm_q, overflow_q;

  // Upper address bits alias onto the line index; request type is not interpreted.
  assign rd_in.line  = ccip_c0_tx.hdr.address[LW-1:0];
  assign rd_in.mdata = ccip_c0_tx.hdr.mdata;
  assign wr_in.line  = ccip_c1_tx.hdr.address[LW-1:0];
  assign wr_in.mdata = ccip_c1_tx.hdr.mdata;
  assign wr_in.data  = ccip_c1_tx.data;
  assign unused_bits = ^{ccip_c0_tx.hdr.req_type, ccip_c0_tx.hdr.address[41:LW],
                         ccip_c1_tx.hdr.req_type, ccip_c1_tx.hdr.sop,
                         ccip_c1_tx.hdr.address[41:LW]};

  hc_ccip_fifo #(.W($bits(rd_ent_t)), .DEPTH(REQ_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (ccip_c0_tx.valid),
    .din_i     (rd_in),
    .pop_i     (rd_pop),
    .dout_o    (rd_out),
    .full_o    (rd_full),
    .empty_o   (rd_empty),
    .cnt_nxt_o (rd_cnt_nxt)
  );

  hc_ccip_fifo #(.W($bits(wr_ent_t)), .DEPTH(REQ_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (ccip_c1_tx.valid),
    .din_i     (wr_in),
    .pop_i     (wr_pop),
    .dout_o    (wr_out),
    .full_o    (wr_full),
    .empty_o   (wr_empty),
    .cnt_nxt_o (wr_cnt_nxt)
  );

  assign rd_pop = ~rd_empty & ~rsp_stall;
  assign wr_pop = ~wr_empty & ~rsp_stall;

  // Same-line read and write popping together: the read sees the write's data.
  assign rd_data_d = (wr_pop && (wr_out.line == rd_out.line)) ? wr_out.data : mem_q[rd_out.line];

  always_ff @(posedge clk) begin
    if (wr_pop) mem_q[wr_out.line] <= wr_out.data;
  end

  always_ff @(posedge clk) begin
    rd_mdata_q[0] <= rd_out.mdata;
    rd_data_q[0]  <= rd_data_d;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_mdata_q[i] <= rd_mdata_q[i-1];
      rd_data_q[i]  <= rd_data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q       <= '0;
      wr_rsp_vld_q   <= 1'b0;
      wr_rsp_mdata_q <= '0;
      rd_alm_q       <= 1'b0;
      wr_alm_q       <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      rd_vld_q[0] <= rd_pop;
      for (int i = 1; i < RD_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1];
      wr_rsp_vld_q   <= wr_pop;
      wr_rsp_mdata_q <= wr_out.mdata;
      rd_alm_q       <= (rd_cnt_nxt >= CW'(ALM_TH));
      wr_alm_q       <= (wr_cnt_nxt >= CW'(ALM_TH));
      overflow_q     <= overflow_q | (ccip_c0_tx.valid & rd_full) | (ccip_c1_tx.valid & wr_full);
    end
  end

  always_comb begin
    ccip_rx                    = '0;
    ccip_rx.c0TxAlmFull        = rd_alm_q;
    ccip_rx.c1TxAlmFull        = wr_alm_q;
    ccip_rx.c0.rspValid        = rd_vld_q[RD_LATENCY-1];
    ccip_rx.c0.hdr.resp_type   = eRSP_RDLINE;
    ccip_rx.c0.hdr.mdata       = rd_mdata_q[RD_LATENCY-1];
    ccip_rx.c0.data            = rd_data_q[RD_LATENCY-1];
    ccip_rx.c1.rspValid        = wr_rsp_vld_q;
    ccip_rx.c1.hdr.resp_type   = eRSP_WRLINE;
    ccip_rx.c1.hdr.mdata       = wr_rsp_mdata_q;
  end

  assign overflow = overflow_q;
endmodule

// File: tb/tb_hc_ccip_responder.sv
// Scoreboard bench for hc_ccip_responder: stimulus queues expected responses, a negedge monitor checks them.
module tb_hc_ccip_responder;
  import hc_ccip_pkg::*;

  localparam int RD_LAT = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           rsp_stall = 1'b0;
  logic           overflow;
  t_if_ccip_c0_Tx c0_tx;
  t_if_ccip_c1_Tx c1_tx;
  t_if_ccip_Rx    rx;

  typedef struct {
    t_ccip_mdata  mdata;
    t_ccip_clData data;
    int           cyc;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  t_ccip_clData a5, d3, d7, d20, dz;

  hc_ccip_responder #(
    .MEM_LINES (1024),
    .REQ_DEPTH (64),
    .ALM_SLACK (8),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ccip_c0_tx(c0_tx),
    .ccip_c1_tx(c1_tx),
    .rsp_stall (rsp_stall),
    .ccip_rx   (rx),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (low 64 bits)", nm, act[63:0], req[63:0]);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rx.c0.rspValid) begin
        if (rd_q.size() == 0) chk("c0_unexpected_rsp", 512'(rx.c0.rspValid), '0);
        else begin
          e0 = rd_q.pop_front();
          chk("c0_mdata", 512'(rx.c0.hdr.mdata), 512'(e0.mdata));
          chk("c0_data", rx.c0.data, e0.data);
          chk("c0_resp_type", 512'(rx.c0.hdr.resp_type), 512'(eRSP_RDLINE));
          if (e0.cyc >= 0) chk("c0_latency_cycle", 512'(cyc), 512'(e0.cyc));
        end
      end
      if (rx.c1.rspValid) begin
        if (wr_q.size() == 0) chk("c1_unexpected_rsp", 512'(rx.c1.rspValid), '0);
        else begin
          e1 = wr_q.pop_front();
          chk("c1_mdata", 512'(rx.c1.hdr.mdata), 512'(e1.mdata));
          chk("c1_resp_type", 512'(rx.c1.hdr.resp_type), 512'(eRSP_WRLINE));
          if (e1.cyc >= 0) chk("c1_ack_cycle", 512'(cyc), 512'(e1.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    c0_tx.valid = 1'b0;
    c1_tx.valid = 1'b0;
  endtask

  task automatic do_rd(input logic [41:0] a, input t_ccip_mdata md, input t_ccip_clData d, input bit timed);
    c0_tx.valid        = 1'b1;
    c0_tx.hdr.address  = a;
    c0_tx.hdr.mdata    = md;
    rd_q.push_back('{mdata: md, data: d, cyc: (timed ? cyc + 1 + RD_LAT : -1)});
  endtask

  task automatic do_wr(input logic [41:0] a, input t_ccip_mdata md, input t_ccip_clData d, input bit timed);
    c1_tx.valid        = 1'b1;
    c1_tx.hdr.address  = a;
    c1_tx.hdr.mdata    = md;
    c1_tx.data         = d;
    wr_q.push_back('{mdata: md, data: d, cyc: (timed ? cyc + 2 : -1)});
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && (rd_q.size() != 0 || wr_q.size() != 0); i++) tick();
    chk({nm, "_rd_left"}, 512'(rd_q.size()), '0);
    chk({nm, "_wr_left"}, 512'(wr_q.size()), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
    $fatal(1);
  end

  initial begin
    a5  = {64{8'hA5}};
    d3  = {8{64'h0123_4567_89AB_CDEF}};
    d7  = 512'h7;
    d20 = {16{32'hDEAD_0020}};
    dz  = '0;
    c0_tx = '0;
    c1_tx = '0;

    repeat (3) tick();
    chk("rst_c0_valid", 512'(rx.c0.rspValid), '0);
    chk("rst_c1_valid", 512'(rx.c1.rspValid), '0);
    chk("rst_c0_almfull", 512'(rx.c0TxAlmFull), '0);
    chk("rst_c1_almfull", 512'(rx.c1TxAlmFull), '0);
    chk("rst_overflow", 512'(overflow), '0);
    reset = 1'b1;
    repeat (2) tick();

    // Write then read line 5 with two idle cycles between.
    do_wr(42'd5, 16'h11, a5, 1'b1);
    tick(); clr();
    tick(); tick();
    do_rd(42'd5, 16'h22, a5, 1'b1);
    tick(); clr();
    drain("wr_rd_line5");

    // Same-cycle read/write pop on line 9: read sees new data.
    do_wr(42'd9, 16'h30, dz, 1'b1);
    tick(); clr();
    drain("line9_init");
    do_wr(42'd9, 16'h31, d7, 1'b1);
    do_rd(42'd9, 16'h32, d7, 1'b1);
    tick(); clr();
    drain("line9_hazard");

    // Address aliasing: 0x403 maps to line 3.
    do_wr(42'd3, 16'h40, d3, 1'b1);
    tick(); clr();
    repeat (3) tick();
    do_rd(42'h403, 16'h41, d3, 1'b1);
    tick(); clr();
    drain("alias");

    // Burst of 32 reads with the stall toggling every 3 cycles.
    for (int i = 0; i < 32; i++) begin
      rsp_stall = ((i / 3) % 2) == 1;
      do_rd(42'd3 | (42'(i) << 10), 16'(i), d3, 1'b0);
      tick();
    end
    clr();
    rsp_stall = 1'b0;
    drain("burst");

    // Fill the read FIFO while stalled: AlmFull at 56, overflow on the 65th.
    rsp_stall = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      do_rd(42'd5, 16'h100 + 16'(j), a5, 1'b0);
      tick();
      if (j == 55) chk("almfull_at_55", 512'(rx.c0TxAlmFull), '0);
      if (j == 56) chk("almfull_at_56", 512'(rx.c0TxAlmFull), 512'(1));
      if (j == 64) chk("no_overflow_at_64", 512'(overflow), '0);
    end
    c0_tx.hdr.mdata = 16'hDEAD;
    tick(); clr();
    chk("overflow_at_65", 512'(overflow), 512'(1));
    chk("c1_almfull_idle", 512'(rx.c1TxAlmFull), '0);
    tick(); tick();
    chk("overflow_sticky", 512'(overflow), 512'(1));
    rsp_stall = 1'b0;
    drain("fill");
    chk("almfull_after_drain", 512'(rx.c0TxAlmFull), '0);

    // Reset with reads queued and in the pipeline.
    rsp_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_rd(42'd5, 16'h200 + 16'(i), a5, 1'b0);
      tick();
    end
    clr();
    rsp_stall = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_c0_valid", 512'(rx.c0.rspValid), '0);
    chk("midrst_c1_valid", 512'(rx.c1.rspValid), '0);
    chk("midrst_almfull", 512'(rx.c0TxAlmFull), '0);
    chk("midrst_overflow", 512'(overflow), '0);
    rd_q.delete();
    wr_q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("postrst_c0_valid", 512'(rx.c0.rspValid), '0);
    do_wr(42'd20, 16'h50, d20, 1'b1);
    tick(); clr();
    repeat (3) tick();
    do_rd(42'd20, 16'h51, d20, 1'b1);
    tick(); clr();
    drain("postrst");
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
